// File: rtl/adc_input_frontend.sv
// adc_input_frontend
//   Serial ADC front end. A clk_en strobe starts one chip-select frame.
//   The frame is FRAME_BITS SCLK cycles long: 4 leading zeros, then
//   12 data bits, MSB first. The captured 12-bit code is converted to
//   a signed Q(WIDTH-FRAC).FRAC sample.
//
//   Optional feature: define ADC_DC_BLOCK_EN to insert a first-order
//   DC blocker (leaky accumulator, shift 8) after the conversion.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   clk_en       one-cycle conversion trigger (sample-rate strobe)
//   adc_sdo      serial data from the ADC
//   adc_cs_n     ADC chip select, active low
//   adc_sclk     ADC serial clock, idle high
//   sample_out   converted sample; holds its value between updates
//   sample_valid one-cycle pulse when sample_out updates
//   busy         high while a frame is in progress
//   overrun      one-cycle pulse for each clk_en that arrives while busy
//
// Timing at defaults:
//   clk_en cycle 0, SETUP cycles 1..4, SHIFT cycles 5..132, DONE cycle 133.
//   sample_out/sample_valid are registered out of DONE, so they appear in
//   cycle 134. busy covers cycles 1..133, so a clk_en in DONE is an
//   overrun, and a clk_en in cycle 134 starts the next frame.
module adc_input_frontend #(
  parameter int WIDTH      = 18,
  parameter int FRAC       = 14,
  parameter int SCLK_DIV   = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    adc_sdo,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  // Mid-scale code 2048, scaled by 2^(FRAC-11), lands on 0.
  localparam logic signed [WIDTH-1:0] OFFSET = WIDTH'(2 ** FRAC);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               phase_hi;
  logic [11:0]        shift_reg;   // the leading frame bits fall out the top
  logic               div_last, bit_last;
  logic [WIDTH-1:0]   code_ext;
  logic signed [WIDTH-1:0] x_raw, x_out;

  assign div_last = (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign bit_last = (bit_cnt == BIT_W'(FRAME_BITS - 1));
  // busy is low in IDLE, so a trigger never counts as an overrun.
  assign overrun  = clk_en & busy;

  assign code_ext = WIDTH'(shift_reg) << (FRAC - 11);
  assign x_raw    = $signed(code_ext) - OFFSET;

`ifdef ADC_DC_BLOCK_EN
  localparam logic signed [WIDTH+8:0] YMAX = (WIDTH+9)'(2 ** (WIDTH-1) - 1);
  localparam logic signed [WIDTH+8:0] YMIN = -(WIDTH+9)'(2 ** (WIDTH-1));

  logic signed [WIDTH+7:0] acc, acc_sh;
  logic signed [WIDTH+8:0] y_wide;

  assign acc_sh = acc >>> 8;
  assign y_wide = (WIDTH+9)'(x_raw) - (WIDTH+9)'(acc_sh);

  always_comb begin
    x_out = y_wide[WIDTH-1:0];
    if (y_wide > YMAX)      x_out = YMAX[WIDTH-1:0];
    else if (y_wide < YMIN) x_out = YMIN[WIDTH-1:0];
  end

  // The accumulator tracks the DC level; it moves once per converted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                acc <= '0;
    else if (state == DONE) acc <= acc + (WIDTH+8)'(x_raw) - acc_sh;
  end
`else
  assign x_out = x_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clk_en) state_nxt = SETUP;
      SETUP:   if (div_last) state_nxt = SHIFT;
      SHIFT:   if (div_last && phase_hi && bit_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      phase_hi     <= 1'b0;
      shift_reg    <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          bit_cnt  <= '0;
          phase_hi <= 1'b0;
          if (clk_en) begin
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (div_last) begin
            div_cnt  <= '0;
            adc_sclk <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          // Capture in the first cycle with SCLK high. The ADC changed
          // SDO on the falling edge, so the data has had half a bit to settle.
          if (phase_hi && div_cnt == '0)
            shift_reg <= {shift_reg[10:0], adc_sdo};
          if (div_last) begin
            div_cnt <= '0;
            if (!phase_hi) begin
              adc_sclk <= 1'b1;
              phase_hi <= 1'b1;
            end else if (bit_last) begin
              adc_cs_n <= 1'b1;       // SCLK is already high, so it stays idle
              phase_hi <= 1'b0;
            end else begin
              adc_sclk <= 1'b0;
              phase_hi <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          busy         <= 1'b0;
          sample_out   <= x_out;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_input_frontend.sv
// Bench for adc_input_frontend at default parameters.
// It contains a serial ADC model that shifts a 16-bit word out on SCLK falling
// edges. A frame-level reference model predicts busy, cs_n, overrun,
// sample_valid and sample_out on every cycle. Directed literal checks pin
// the latency and the conversion mapping.
module tb_adc_input_frontend;

  localparam int LAT = 134;
`ifdef ADC_DC_BLOCK_EN
  localparam int DC_FRAMES = 2000;
  localparam longint TIMEOUT = 64'd5_000_000;
`else
  localparam int DC_FRAMES = 5;
  localparam longint TIMEOUT = 64'd400_000;
`endif

  logic clk = 0, rst = 1, clk_en = 0, adc_sdo = 0;
  logic adc_cs_n, adc_sclk, sample_valid, busy, overrun;
  logic signed [17:0] sample_out;

  int tests = 0, fails = 0;
  int cyc = 0;

  adc_input_frontend dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .adc_sdo(adc_sdo),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int val; } exp_t;
  exp_t         exp_q[$];
  logic [15:0]  word_q[$];
  logic [15:0]  adc_word = 16'h0;
  bit           in_frame = 0;
  int           ts = 0;
  int           hold_val = 0;
  longint       m_acc = 0;

  function automatic int conv(input logic [15:0] w);
    return int'(w[11:0]) * 8 - 16384;
  endfunction

  function automatic int model_out(input int x);
`ifdef ADC_DC_BLOCK_EN
    longint y;
    y = x - (m_acc >>> 8);
    if (y > 131071) y = 131071;
    if (y < -131072) y = -131072;
    m_acc = m_acc + x - (m_acc >>> 8);
    return int'(y);
`else
    return x;
`endif
  endfunction

  // Compare process: checks every cycle, mid-cycle after inputs are driven.
  always begin
    bit busy_e, cs_e, ov_e, val_e;
    exp_t e;
    logic [15:0] w;
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      in_frame = 0;
      hold_val = 0;
      m_acc    = 0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_cs_n", adc_cs_n, 1);
      chk("rst_sclk", adc_sclk, 1);
      chk("rst_sample", int'(sample_out), 0);
    end else begin
      busy_e = in_frame && (cyc > ts) && (cyc <= ts + LAT - 1);
      cs_e   = !(in_frame && (cyc > ts) && (cyc <= ts + LAT - 2));
      ov_e   = clk_en && busy_e;
      val_e  = 0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        val_e = 1;
        hold_val = e.val;
      end
      chk("busy", busy, busy_e);
      chk("cs_n", adc_cs_n, cs_e);
      chk("overrun", overrun, ov_e);
      chk("sample_valid", sample_valid, val_e);
      chk("sample_out", int'(sample_out), hold_val);
      if (clk_en && !busy_e) begin
        in_frame = 1;
        ts = cyc;
        if (word_q.size() > 0) w = word_q.pop_front();
        else                   w = 16'($urandom);
        adc_word = w;
        e.due = cyc + LAT;
        e.val = model_out(conv(w));
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- ADC model ----------------
  always begin
    logic [15:0] fw;
    int k, falls;
    bit prev_cs, prev_sclk;
    prev_cs = 1; prev_sclk = 1; k = 0; falls = 0; fw = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (prev_cs && !adc_cs_n) begin fw = adc_word; k = 0; falls = 0; end
        if (!adc_cs_n && prev_sclk && !adc_sclk) begin
          if (k < 16) adc_sdo = fw[15-k];
          k++;
          falls++;
        end
        if (!prev_cs && adc_cs_n) chk("sclk_falls", falls, 16);
      end
      prev_cs = adc_cs_n;
      prev_sclk = adc_sclk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input logic [15:0] w, output int lat, output int val);
    int t0;
    word_q.push_back(w);
    @(negedge clk); clk_en = 1; t0 = cyc;
    @(negedge clk); clk_en = 0;
    while (!sample_valid && (cyc - t0) < 300) @(negedge clk);
    if (!sample_valid) chk("valid_timeout", 0, 1);
    lat = cyc - t0;
    val = int'(sample_out);
  endtask

  initial begin
    int lat, val, t0, nval, first_dc;
    logic [15:0] lit_w [4] = '{16'h0800, 16'h0000, 16'h0FFF, 16'hF800};
    int          lit_v [4] = '{0, -16384, 16376, 0};

    repeat (3) @(negedge clk);
    chk("init_cs_n", adc_cs_n, 1);
    chk("init_sclk", adc_sclk, 1);
    chk("init_sample", int'(sample_out), 0);
    chk("init_overrun", overrun, 0);
    rst = 0;

    // Mapping and latency.
    for (int i = 0; i < 4; i++) begin
      run_frame(lit_w[i], lat, val);
      chk("latency", lat, LAT);
`ifndef ADC_DC_BLOCK_EN
      chk("mapping", val, lit_v[i]);
`endif
    end

    // A second clk_en mid-frame is an overrun and does not extend the frame.
    word_q.push_back(16'h0800);
    @(negedge clk); clk_en = 1; t0 = cyc;
    @(negedge clk); clk_en = 0;
    while (cyc < t0 + 50) @(negedge clk);
    clk_en = 1;
    #1 chk("overrun_pulse", overrun, 1);
    @(negedge clk); clk_en = 0;
    #1 chk("overrun_clear", overrun, 0);
    while (!sample_valid && (cyc - t0) < 300) @(negedge clk);
    chk("overrun_latency", cyc - t0, LAT);

    // Reset in the middle of a frame.
    @(negedge clk);
    word_q.push_back(16'h0FFF);
    @(negedge clk); clk_en = 1; t0 = cyc;
    @(negedge clk); clk_en = 0;
    while (cyc < t0 + 70) @(negedge clk);
    #1 rst = 1;
    #1 chk("abort_cs_n", adc_cs_n, 1);
    chk("abort_sclk", adc_sclk, 1);
    repeat (3) @(negedge clk);
    rst = 0;
    nval = 0;
    repeat (140) begin @(negedge clk); if (sample_valid) nval++; end
    chk("abort_no_valid", nval, 0);

    // Constant code 3072: raw mapping is 8192; the DC blocker decays it.
    first_dc = 0;
    for (int i = 0; i < DC_FRAMES; i++) begin
      run_frame(16'h0C00, lat, val);
      if (i == 0) begin
        chk("const_first", val, 8192);
        chk("const_latency", lat, LAT);
      end
`ifndef ADC_DC_BLOCK_EN
      else chk("const_hold", val, 8192);
`endif
    end
`ifdef ADC_DC_BLOCK_EN
    chk("dc_decay_small", (val < 100 && val > -100) ? 1 : 0, 1);
`endif

    // Random triggers, including overruns and back-to-back frames.
    repeat (4000) begin
      @(negedge clk);
      clk_en = ($urandom_range(0, 99) < 4);
    end
    @(negedge clk); clk_en = 0;
    repeat (200) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(TIMEOUT);
    $display("FAIL watchdog: simulation did not finish within %0d time units", TIMEOUT);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
